neuron_mac_stage: RTL and testbench

//  Streaming dot-product neuron that sits directly downstream of the image loader.
//  - Consumes N_INPUTS pixel words on the x_t* AXI-Stream-style handshake.
//  - Multiplies each pixel by a weight read from an external 1-cycle-latency BRAM port, accumulates, adds bias.
//  - Rescales and saturates, then presents one result word on the y_t* handshake.

---
 rtl/neuron_mac_stage.sv | 179 +++++++++++++++++
 tb/tb_neuron_mac_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_stage.sv
// ---------------------------------------------------------------------------
// neuron_mac_stage
//
// Streaming dot-product neuron. Accepts N_INPUTS signed pixel words, multiplies
// each one by a weight fetched from an external BRAM with one cycle of read
// latency, accumulates, adds a bias, rescales and saturates. It then offers one
// result word on an output handshake.
//
// Build option:
//   RELU_EN  when defined, negative saturated results are replaced by zero.
//
// Ports:
//   s_axi_aclk    clock
//   s_axi_areset  asynchronous reset, active-high
//   x_tdata       pixel, low DATA_W bits used (signed)
//   x_tvalid      pixel valid
//   x_tready      stage can accept a pixel (only while accumulating)
//   w_addr        weight BRAM byte address, combinational (word i at 4*i)
//   w_data        weight BRAM read data, low DATA_W bits used (signed)
//   bias          bias in the same Q format, low DATA_W bits used (signed)
//   y_tdata       result, sign-extended from DATA_W to 32 bits
//   y_tvalid      result valid
//   y_tready      consumer accepts result
//   busy          high whenever the stage is not in its priming cycle
// ---------------------------------------------------------------------------
module neuron_mac_stage #(
    parameter int N_INPUTS  = 784,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ADDR_W    = 32
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic [31:0]       x_tdata,
    input  logic              x_tvalid,
    output logic              x_tready,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [31:0]       w_data,
    input  logic [31:0]       bias,
    output logic [31:0]       y_tdata,
    output logic              y_tvalid,
    input  logic              y_tready,
    output logic              busy
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    // Sized so that N_INPUTS full-scale products plus the bias cannot overflow.
    localparam int ACC_W = 2 * DATA_W + $clog2(N_INPUTS) + 1;

    localparam logic [1:0] ST_PRIME = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_BIAS  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]               state_reg;
    logic [1:0]               state_next;
    logic [CNT_W-1:0]         in_cnt_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [DATA_W-1:0]        y_data_reg;
    logic                     y_valid_reg;

    logic                     accept;
    logic                     last_beat;
    logic [CNT_W-1:0]         addr_idx;
    logic signed [DATA_W-1:0] x_s;
    logic signed [DATA_W-1:0] w_s;
    logic signed [DATA_W-1:0] bias_s;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_biased;
    logic signed [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0]        sat_val;
    logic [DATA_W-1:0]        result;
    logic                     unused_upper;

    // Only the low DATA_W bits of the 32-bit buses carry data.
    assign unused_upper = &{1'b0, x_tdata[31:DATA_W], w_data[31:DATA_W], bias[31:DATA_W]};

    assign x_tready  = (state_reg == ST_ACC);
    assign accept    = x_tvalid & x_tready;
    assign last_beat = (in_cnt_reg == CNT_W'(N_INPUTS - 1));
    assign busy      = (state_reg != ST_PRIME);

    // Look one word ahead on an accepted beat, so that w_data already holds
    // the weight for the next beat when that beat arrives.
    assign addr_idx = accept ? (in_cnt_reg + CNT_W'(1)) : in_cnt_reg;
    assign w_addr   = ADDR_W'(addr_idx) << 2;

    assign x_s    = x_tdata[DATA_W-1:0];
    assign w_s    = w_data[DATA_W-1:0];
    assign bias_s = bias[DATA_W-1:0];
    assign prod   = x_s * w_s;

    assign prod_ext   = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // The bias is in the input Q format. The accumulator is in the product
    // format, which has twice the fractional bits, so the bias is aligned
    // by FRAC_BITS.
    assign bias_ext   = {{(ACC_W - DATA_W - FRAC_BITS){bias_s[DATA_W-1]}}, bias_s,
                         {FRAC_BITS{1'b0}}};
    assign acc_biased = acc_reg + bias_ext;
    assign shifted    = acc_biased >>> FRAC_BITS;

    always_comb begin
        sat_val = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end
    end

`ifdef RELU_EN
    assign result = sat_val[DATA_W-1] ? '0 : sat_val;
`else
    assign result = sat_val;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_PRIME: state_next = ST_ACC;
            ST_ACC:   if (accept && last_beat) state_next = ST_BIAS;
            ST_BIAS:  state_next = ST_OUT;
            ST_OUT:   if (y_tready) state_next = ST_PRIME;
            default:  state_next = ST_PRIME;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_reg   <= ST_PRIME;
            in_cnt_reg  <= '0;
            acc_reg     <= '0;
            y_data_reg  <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_ACC: begin
                    if (accept) begin
                        acc_reg    <= acc_reg + prod_ext;
                        in_cnt_reg <= in_cnt_reg + CNT_W'(1);
                    end
                end
                ST_BIAS: begin
                    acc_reg     <= acc_biased;
                    y_data_reg  <= result;
                    y_valid_reg <= 1'b1;
                end
                ST_OUT: begin
                    if (y_tready) begin
                        y_valid_reg <= 1'b0;
                        in_cnt_reg  <= '0;
                        acc_reg     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y_tvalid = y_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_y_ext
            if (gi < DATA_W) begin : g_data
                assign y_tdata[gi] = y_data_reg[gi];
            end else begin : g_sign
                assign y_tdata[gi] = y_data_reg[DATA_W-1];
            end
        end
    endgenerate

endmodule

// File: tb/tb_neuron_mac_stage.sv
// Testbench for neuron_mac_stage with N_INPUTS=4, DATA_W=16, FRAC_BITS=8.
// Runs a directed vector table, a mid-frame reset sequence, and random frames.
// Random frames are checked against an arithmetic reference model.
module tb_neuron_mac_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x_tdata;
    logic        x_tvalid;
    logic        x_tready;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [31:0] bias;
    logic [31:0] y_tdata;
    logic        y_tvalid;
    logic        y_tready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [8];

    always #5 clk = ~clk;

    neuron_mac_stage #(
        .N_INPUTS(4), .DATA_W(16), .FRAC_BITS(8), .ADDR_W(32)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
        .w_addr(w_addr), .w_data(w_data), .bias(bias),
        .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tready(y_tready),
        .busy(busy)
    );

    // Weight BRAM: one cycle read latency; addresses past the table read 0.
    always @(posedge clk) begin
        w_data <= (w_addr[31:2] < 30'd8) ? mem[w_addr[4:2]] : 32'h0;
    end

    typedef struct {
        logic [63:0] xs;
        logic [63:0] ws;
        logic [31:0] b;
        int          gap;
        int          stall;
        logic [31:0] y_plain;
        logic [31:0] y_relu;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: dot product plus bias in product scale, then floor-divide by
    // 2^FRAC_BITS, clamp to 16-bit signed range, then apply optional ReLU.
    function automatic logic [31:0] model(input logic [63:0] xs, input logic [63:0] ws,
                                          input logic [31:0] b);
        longint s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s += longint'($signed(xs[k*16 +: 16])) * longint'($signed(ws[k*16 +: 16]));
        end
        s += longint'($signed(b[15:0])) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        return 32'(s);
    endfunction

    function automatic logic [15:0] rnd16();
        int r;
        r = $urandom_range(0, 2);
        if (r == 0) return 16'($urandom);
        if (r == 1) return 16'($urandom_range(0, 1023) - 512);
        return 16'($urandom_range(0, 3));
    endfunction

    // Call this while the DUT sits in its priming cycle. It returns in the
    // priming cycle that follows the result handshake.
    task automatic run_frame(input logic [63:0] xs, input logic [63:0] ws, input logic [31:0] b,
                             input int gap, input int stall, input logic [31:0] exp_y,
                             input string tag);
        int i;
        int cyc;
        logic v;
        logic [31:0] y_seen;
        i = 0;
        cyc = 0;
        for (int k = 0; k < 4; k++) mem[k] = {16'($urandom), ws[k*16 +: 16]};
        bias = {16'($urandom), b[15:0]};
        y_tready = (stall == 0);
        while (i < 4 && cyc < 64) begin
            @(posedge clk); #1;
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            x_tvalid = v;
            x_tdata  = v ? {16'($urandom), xs[i*16 +: 16]} : $urandom;
            #1;
            check("x_tready_acc", 32'(x_tready), 32'd1);
            check("w_addr", w_addr, v ? 32'(4 * (i + 1)) : 32'(4 * i));
            check("y_tvalid_early", 32'(y_tvalid), 32'd0);
            if (v && x_tready) i++;
            cyc++;
        end
        if (i < 4) check("beat_timeout", 32'(i), 32'd4);
        @(posedge clk); #1;
        x_tvalid = 1'b0;
        x_tdata  = $urandom;
        #1;
        check("y_tvalid_bias", 32'(y_tvalid), 32'd0);
        check("x_tready_bias", 32'(x_tready), 32'd0);
        check("w_addr_bias", w_addr, 32'd16);
        check("busy_bias", 32'(busy), 32'd1);
        @(posedge clk); #2;
        check("latency_y_tvalid", 32'(y_tvalid), 32'd1);
        check("y_tdata", y_tdata, exp_y);
        y_seen = y_tdata;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #2;
            check("stall_y_tvalid", 32'(y_tvalid), 32'd1);
            check("stall_y_stable", y_tdata, exp_y);
            check("stall_x_tready", 32'(x_tready), 32'd0);
        end
        y_tready = 1'b1;
        @(posedge clk); #2;
        check("prime_y_tvalid", 32'(y_tvalid), 32'd0);
        check("prime_x_tready", 32'(x_tready), 32'd0);
        check("prime_busy", 32'(busy), 32'd0);
        check("prime_w_addr", w_addr, 32'd0);
        $display("frame %s y=%08h exp=%08h", tag, y_seen, exp_y);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] xs;
        logic [63:0] ws;
        logic [31:0] b;
        logic [31:0] e;

        //            xs               ws               bias    gap stall plain        relu
        tbl[0] = '{{4{16'h0100}}, {4{16'h0100}}, 32'h0,    0, 0, 32'h00000400, 32'h00000400};
        tbl[1] = '{{4{16'h0100}}, {4{16'h0100}}, 32'h0,    1, 4, 32'h00000400, 32'h00000400};
        tbl[2] = '{{4{16'h7FFF}}, {4{16'h7FFF}}, 32'h0,    0, 0, 32'h00007FFF, 32'h00007FFF};
        tbl[3] = '{{4{16'h8000}}, {4{16'h7FFF}}, 32'h0,    0, 1, 32'hFFFF8000, 32'h00000000};
        tbl[4] = '{{4{16'h0000}}, {4{16'h0100}}, 32'hFF00, 0, 0, 32'hFFFFFF00, 32'h00000000};
        tbl[5] = '{{4{16'h0100}}, {4{16'h0100}}, 32'h0,    0, 0, 32'h00000400, 32'h00000400};
        tbl[6] = '{{4{16'h0200}}, {4{16'h0100}}, 32'h0,    0, 0, 32'h00000800, 32'h00000800};

        rst      = 1'b1;
        x_tvalid = 1'b0;
        x_tdata  = '0;
        y_tready = 1'b0;
        bias     = '0;
        for (int k = 0; k < 8; k++) mem[k] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_x_tready", 32'(x_tready), 32'd0);
        check("rst_y_tvalid", 32'(y_tvalid), 32'd0);
        check("rst_y_tdata", y_tdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_w_addr", w_addr, 32'd0);
        #1 rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
`ifdef RELU_EN
            e = tbl[t].y_relu;
`else
            e = tbl[t].y_plain;
`endif
            run_frame(tbl[t].xs, tbl[t].ws, tbl[t].b, tbl[t].gap, tbl[t].stall, e,
                      $sformatf("vec%0d", t));
        end

        // Reset pulse after two accepted beats of a frame.
        for (int k = 0; k < 4; k++) mem[k] = 32'h0100;
        bias = '0;
        @(posedge clk); #1;
        x_tvalid = 1'b1;
        x_tdata  = 32'h0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        x_tvalid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_y_tvalid", 32'(y_tvalid), 32'd0);
        check("midrst_x_tready", 32'(x_tready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_w_addr", w_addr, 32'd0);
        check("midrst_y_tdata", y_tdata, 32'd0);
        #1 rst = 1'b0;
        run_frame({4{16'h0100}}, {4{16'h0100}}, 32'h0, 0, 0, 32'h00000400, "after_reset");

        // Random frames against the reference model.
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 4; k++) begin
                xs[k*16 +: 16] = rnd16();
                ws[k*16 +: 16] = rnd16();
            end
            b = {16'($urandom), rnd16()};
            run_frame(xs, ws, b, 2, $urandom_range(0, 3), model(xs, ws, b),
                      $sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
